heartbeat: RTL and testbench

//  Drives a 6-digit seven-segment display with a "heartbeat" animation: a pair of

---
 rtl/heartbeat_pkg.sv | 20 ++
 rtl/heartbeat_tick.sv | 34 +++
 rtl/heartbeat.sv | 73 +++++++
 tb/tb_heartbeat.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/heartbeat_pkg.sv
// Shared definitions for the heartbeat display animation: segment codes,
// phase encoding and the tick-counter width helper.
package heartbeat_pkg;

    // Segment codes are {dp,g,f,e,d,c,b,a}, active-low; dp stays dark.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_RBAR  = 8'hF9;
    localparam logic [7:0] SEG_LBAR  = 8'hCF;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2
    } phase_e;

    function automatic int unsigned tick_width(input int unsigned turns);
        return (turns <= 1) ? 1 : $clog2(turns);
    endfunction

endpackage

// File: rtl/heartbeat_tick.sv
// Free-running tick counter that wraps after `turns` cycles and pulses
// `advance` for one cycle on the wrapping count.
module heartbeat_tick
    import heartbeat_pkg::*;
#(
    parameter int unsigned turns = 1_388_889
) (
    input  logic clk,
    input  logic rst_n,
    output logic advance
);

    localparam int unsigned W = tick_width(turns);
    localparam logic [W-1:0] LAST = W'(turns - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        advance = (count_q == LAST);
        count_d = advance ? '0 : count_q + ONE;
    end

    // rst_n is active-high: 1 clears the counter and wins over counting.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/heartbeat.sv
// Heartbeat animation for a 6-digit display: a pair of bars steps outward
// from the centre, each pattern held for `turns` cycles.
module heartbeat
    import heartbeat_pkg::*;
#(
    parameter int unsigned turns = 1_388_889
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] in0,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic [7:0] in3,
    output logic [7:0] in4,
    output logic [7:0] in5
);

    logic   advance;
    phase_e phase_q;
    phase_e phase_d;

    heartbeat_tick #(
        .turns (turns)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            phase_q <= P0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // The unused encoding falls back to P0 without waiting for an advance.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            P0:      if (advance) phase_d = P1;
            P1:      if (advance) phase_d = P2;
            P2:      if (advance) phase_d = P0;
            default: phase_d = P0;
        endcase
    end

    always_comb begin
        in0 = SEG_BLANK;
        in1 = SEG_BLANK;
        in2 = SEG_BLANK;
        in3 = SEG_BLANK;
        in4 = SEG_BLANK;
        in5 = SEG_BLANK;
        case (phase_q)
            P0: begin
                in3 = SEG_RBAR;
                in2 = SEG_LBAR;
            end
            P1: begin
                in4 = SEG_RBAR;
                in1 = SEG_LBAR;
            end
            P2: begin
                in5 = SEG_RBAR;
                in0 = SEG_LBAR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_heartbeat.sv
// Self-checking bench: a turns=10 and a turns=1 heartbeat run in lockstep from
// one reset, driven by a vector table with a scoreboard, plus timing sequences.
`timescale 1ns/1ps
module tb_heartbeat;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a0, a1, a2, a3, a4, a5;
    logic [7:0] b0, b1, b2, b3, b4, b5;

    int errors = 0;
    int checks = 0;
    int k = 0;

    typedef struct {
        logic        rst;
        logic [47:0] exp10;
        logic [47:0] exp1;
    } vec_t;

    typedef struct {
        logic [47:0] exp10;
        logic [47:0] exp1;
    } sb_t;

    vec_t vecs[$];
    sb_t  scoreboard[$];

    always #5 clk = ~clk;

    heartbeat #(.turns(10)) dutA (
        .clk(clk), .rst_n(rst),
        .in0(a0), .in1(a1), .in2(a2), .in3(a3), .in4(a4), .in5(a5)
    );

    heartbeat #(.turns(1)) dutB (
        .clk(clk), .rst_n(rst),
        .in0(b0), .in1(b1), .in2(b2), .in3(b3), .in4(b4), .in5(b5)
    );

    // Reference patterns as {in5,in4,in3,in2,in1,in0}.
    function automatic logic [47:0] patternFor(input int ph);
        case (ph)
            0:       return {8'hFF, 8'hFF, 8'hF9, 8'hCF, 8'hFF, 8'hFF};
            1:       return {8'hFF, 8'hF9, 8'hFF, 8'hFF, 8'hCF, 8'hFF};
            default: return {8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hCF};
        endcase
    endfunction

    function automatic logic shapeOk(input logic [47:0] v);
        int lit = 0;
        logic ok = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (v[d*8 +: 8] != 8'hFF) lit++;
            if (v[d*8 + 7] != 1'b1) ok = 1'b0;
        end
        return ok && (lit == 2);
    endfunction

    task automatic checkVal(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // k counts clock edges since the last reset release; phase = (k/turns) mod 3.
    task automatic addRun(input logic r, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            if (r) k = 0;
            else   k++;
            v.rst   = r;
            v.exp10 = patternFor((k / 10) % 3);
            v.exp1  = patternFor(k % 3);
            vecs.push_back(v);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sb_t e;
        @(negedge clk);
        rst     = v.rst;
        e.exp10 = v.exp10;
        e.exp1  = v.exp1;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        sb_t e;
        logic [47:0] actA;
        logic [47:0] actB;
        actA = {a5, a4, a3, a2, a1, a0};
        actB = {b5, b4, b3, b2, b1, b0};
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty at vector %0d: got 0 entries expected 1", idx);
            return;
        end
        e = scoreboard.pop_front();
        checkVal($sformatf("turns10_vec%0d", idx), actA, e.exp10);
        checkVal($sformatf("turns1_vec%0d", idx), actB, e.exp1);
        checkVal($sformatf("shape10_vec%0d", idx), 48'(shapeOk(actA)), 48'd1);
        checkVal($sformatf("shape1_vec%0d", idx), 48'(shapeOk(actB)), 48'd1);
    endtask

    initial begin
        int firstChangeA;
        int firstReturnB;
        logic bLeft;

        // Reset, run through P0,P1,P2,P0, then reset mid-P2 at count 5 and recover.
        addRun(1'b1, 3);
        addRun(1'b0, 55);
        addRun(1'b1, 1);
        addRun(1'b0, 22);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
            if (i == 2) begin
                checkVal("counter_after_reset", 48'(dutA.u_tick.count_q), 48'd0);
            end
        end

        // Hold time after a release, and turns=1 period.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        firstChangeA = -1;
        firstReturnB = -1;
        bLeft = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (firstChangeA < 0 && {a5, a4, a3, a2, a1, a0} != patternFor(0)) firstChangeA = n;
            if ({b5, b4, b3, b2, b1, b0} != patternFor(0)) bLeft = 1'b1;
            else if (bLeft && firstReturnB < 0) firstReturnB = n;
        end
        checkVal("first_change_turns10", 48'(firstChangeA), 48'd10);
        checkVal("period_turns1", 48'(firstReturnB), 48'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
